// File: rtl/square_rr_arbiter.sv
// square_rr_arbiter: shares one 4-bit squarer among NREQ requesters.
// Requesters are served in round-robin order through valid/ready handshakes.
// Each result lands in a single registered output stage, tagged with the
// requester ID. A wrapping counter tracks how many results downstream consumed.

// square_4bit: the shared combinational 4-bit squarer (exact in 8 bits).
module square_4bit (
    input  logic [3:0] i_a,
    output logic [7:0] o_p
);
    logic [7:0] w_aExt;

    assign w_aExt = {4'b0000, i_a};
    assign o_p    = w_aExt * w_aExt;
endmodule

module square_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_a,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    output logic [7:0]          out_p,
    output logic [ID_W-1:0]     out_id,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    done_cnt
);
    logic [ID_W-1:0]  r_rrPtr;
    logic             r_outValid;
    logic [7:0]       r_outP;
    logic [ID_W-1:0]  r_outId;
    logic [CNT_W-1:0] r_doneCnt;

    logic             w_hasWin;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_nextPtr;
    logic             w_canAccept;
    logic             w_accept;
    logic [3:0]       w_operand;
    logic [7:0]       w_square;

    // The output slot can take a new result when it is empty or being drained.
    assign w_canAccept = !r_outValid || out_ready;
    assign w_accept    = w_hasWin && w_canAccept && !rst;

    // Round-robin search: the first valid requester at or after the pointer,
    // wrapping modulo NREQ.
    always_comb begin
        w_hasWin = 1'b0;
        w_win    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(r_rrPtr) + k) % NREQ;
            if (!w_hasWin && req_valid[idx]) begin
                w_hasWin = 1'b1;
                w_win    = ID_W'(idx);
            end
        end
    end

    // The grant is one-hot on the winner. It is held low during reset and while
    // the output slot is blocked.
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign w_nextPtr = ID_W'((int'(w_win) + 1) % NREQ);
    assign w_operand = req_a[4*w_win +: 4];

    square_4bit u_square (
        .i_a (w_operand),
        .o_p (w_square)
    );

    // The output register captures accepted results and drops valid once the
    // result is consumed. The pointer only moves past the winner on an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outP     <= '0;
            r_outId    <= '0;
            r_rrPtr    <= '0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_outP     <= w_square;
            r_outId    <= w_win;
            r_rrPtr    <= w_nextPtr;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // The debug counter counts results handed downstream and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_doneCnt <= '0;
        end else if (r_outValid && out_ready) begin
            r_doneCnt <= r_doneCnt + CNT_W'(1);
        end
    end

    assign out_valid = r_outValid;
    assign out_p     = r_outP;
    assign out_id    = r_outId;
    assign done_cnt  = r_doneCnt;
endmodule

// File: doc/square_rr_arbiter.md
Name: square_rr_arbiter

Overview:
- Shares one 4-bit squaring datapath among NREQ independent requesters, using round-robin arbitration and per-requester valid/ready handshakes.
- Instantiates the team's existing square_4bit squarer. Its input comes from the granted requester's operand; its 8-bit result is captured in a single registered output stage tagged with the requester ID.
- Sits between operand-producing blocks and any downstream consumer. Also keeps a running count of completed transactions for debug.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal ceil(log2(NREQ)).
- CNT_W, 16, width of completed-transaction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i presents an operand.
- req_a  in  4*NREQ  operand of requester i at bits [4i+3:4i].
- req_ready  out  NREQ  bit i: requester i's operand is accepted this cycle.
- out_valid  out  1  result register holds a valid result.
- out_p  out  8  square of the accepted operand.
- out_id  out  ID_W  index of the requester whose operand produced out_p.
- out_ready  in  1  downstream accepts the result this cycle.
- done_cnt  out  CNT_W  number of results consumed downstream (out_valid & out_ready).

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_p=0, out_id=0, done_cnt=0, rr_ptr=0. req_ready is 0 during any cycle in which rst=1.
- Slot free: can_accept = !out_valid | out_ready. The output register is a pipeline stage that permits full throughput.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping modulo NREQ.
  - The first asserted index is the winner.
  - If no bit is set, there is no grant.
- req_ready is one-hot or zero: req_ready[win]=1 only when a winner exists, can_accept=1 and rst=0. All other bits are 0.
- req_ready depends combinationally on req_valid and out_ready; there are no combinational paths from req_a.
- Accept (req_valid[win] & req_ready[win]) at posedge:
  - out_p <= square(req_a[win]).
  - out_id <= win.
  - out_valid <= 1.
  - rr_ptr <= (win+1) mod NREQ.
- Latency: the result is visible one cycle after acceptance. Throughput is one result per cycle while out_ready=1.
- No accept while out_valid=1 and out_ready=1: out_valid <= 0. out_p and out_id hold their last values.
- Stall (out_valid=1, out_ready=0): out_p, out_id and out_valid hold; all req_ready=0; rr_ptr holds.
- Simultaneous consume and accept in one cycle: the new result replaces the old one, out_valid stays 1, and done_cnt increments.
- rr_ptr changes only on acceptance. An idle cycle or a stall does not advance it.
- Fairness: a requester holding req_valid is granted within NREQ accepts.
- Requesters must hold req_valid and req_a stable until req_ready. The block does not check this.
- done_cnt increments by 1 on each cycle with out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Arithmetic: out_p = a*a, unsigned, exact in 8 bits (max 15*15 = 225 = 0xE1).
- Reset mid-operation: a pending result is discarded. out_valid=0 in the cycle after the reset edge, with no output for in-flight data.

Test Plan:
- Reset while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_p=0, out_id=0, done_cnt=0, req_ready=0 while rst=1.
- Single request: req_valid=0001, req_a[3:0]=13, out_ready=1 -> req_ready=0001 in the same cycle; next cycle out_valid=1, out_p=169, out_id=0; done_cnt=1 one cycle later.
- All four requesters valid continuously with operands 15, 1, 0, 7 and out_ready=1 -> grants in order 0,1,2,3,0,...; out_p sequence 225, 1, 0, 49; out_id 0,1,2,3; one result per cycle.
- Back-pressure: result 225 pending, out_ready=0 for 3 cycles with all req_valid=1 -> req_ready=0000, out_p=225 held and rr_ptr unchanged. On out_ready=1, the next grant goes to the following requester in round-robin order.
- Fairness after a gap: requester 2 is granted, then only requesters 0 and 3 are valid -> requester 3 is granted before 0.
- Counter wrap (CNT_W=4): 17 consumed results -> done_cnt=1.
